// File: rtl/pcie_pixel_packer_pkg.sv
// Shared types for the PCIe pixel packer: beat payload, FSM states, bus geometry.
// Optional statistics counters are enabled with PCIE_PIXEL_PACKER_STATS_EN.
package pcie_pixel_packer_pkg;

  localparam int unsigned PCIE_DATA_W      = 128;
  localparam int unsigned CH_BITS          = 8;
  localparam int unsigned PCIE_BURST_BYTES = 65536;
  localparam int unsigned SLOT_W           = 16;
  localparam int unsigned PAD_W            = 4;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_FRAME = 1'b1
  } packer_state_t;

  typedef struct packed {
    logic                   valid;
    logic [PCIE_DATA_W-1:0] data;
    logic [SLOT_W-1:0]      slot;
    logic [PAD_W-1:0]       pad;
    logic                   last;
  } PCIEPacket;

endpackage

// File: rtl/pcie_burst_counter.sv
// Beat counter marking the final beat of each PCIe burst; a forced last restarts the burst.
// Part of pcie_pixel_packer (optional stats under PCIE_PIXEL_PACKER_STATS_EN live in the top).
module pcie_burst_counter #(
  parameter int unsigned BURST_BEATS = 4096
) (
  input  logic clk,
  input  logic rst_n,
  input  logic beat,
  input  logic force_last,
  output logic last
);

  localparam int unsigned CNT_W = (BURST_BEATS > 1) ? $clog2(BURST_BEATS) : 1;

  if (BURST_BEATS < 1) begin : g_bad_burst
    $error("pcie_burst_counter: BURST_BEATS must be >= 1");
  end

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // last is combinational so the packer can register it with the beat it belongs to
  always_comb begin
    last  = force_last || (cnt_q == CNT_W'(BURST_BEATS - 1));
    cnt_d = cnt_q;
    if (beat) begin
      cnt_d = last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/pcie_pixel_packer.sv
// Packs a valid-only pixel stream into 128-bit PCIe beats with burst/end-of-image last.
// Define PCIE_PIXEL_PACKER_STATS_EN to add saturating beats_sent/frames_sent counters.
module pcie_pixel_packer
  import pcie_pixel_packer_pkg::*;
#(
  parameter int unsigned CHANNELS        = 3,
  parameter int unsigned PIXELS_PER_BEAT = 5,
  parameter int unsigned BURST_BEATS     = PCIE_BURST_BYTES / (PCIE_DATA_W / 8)
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [SLOT_W-1:0]           slot_id,
  input  logic                        pix_valid,
  input  logic [CHANNELS*CH_BITS-1:0] pix_data,
  input  logic                        pix_eof,
  output PCIEPacket                   pcie_packet_out,
  output logic                        frame_active
`ifdef PCIE_PIXEL_PACKER_STATS_EN
  ,
  output logic [31:0]                 beats_sent,
  output logic [15:0]                 frames_sent
`endif
);

  localparam int unsigned PW     = CHANNELS * CH_BITS;
  localparam int unsigned FILL_W = (PIXELS_PER_BEAT > 1) ? $clog2(PIXELS_PER_BEAT) : 1;

  if ((CHANNELS == 0) || (PIXELS_PER_BEAT == 0) || (PW * PIXELS_PER_BEAT > PCIE_DATA_W))
  begin : g_bad_geom
    $error("pcie_pixel_packer: CHANNELS*8*PIXELS_PER_BEAT must be in 1..128");
  end

  packer_state_t          state_q, state_d;
  logic [FILL_W-1:0]      fill_q, fill_d;
  logic [PCIE_DATA_W-1:0] asm_q, asm_d;
  logic [SLOT_W-1:0]      slot_q, slot_d;
  logic                   fa_q, fa_d;
  PCIEPacket              out_q, out_d;

  logic [PCIE_DATA_W-1:0] merged;
  logic [SLOT_W-1:0]      beat_slot;
  logic                   beat_c;
  logic                   burst_last;

  pcie_burst_counter #(
    .BURST_BEATS(BURST_BEATS)
  ) u_burst (
    .clk       (clk),
    .rst_n     (rst),
    .beat      (beat_c),
    .force_last(pix_valid && pix_eof),
    .last      (burst_last)
  );

  // Assembly register is separate from the output register so pixels keep flowing
  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    asm_d     = asm_q;
    slot_d    = slot_q;
    fa_d      = fa_q;
    out_d     = '0;
    beat_c    = 1'b0;
    merged    = asm_q;
    beat_slot = (state_q == S_IDLE) ? slot_id : slot_q;

    for (int unsigned k = 0; k < PIXELS_PER_BEAT; k++) begin
      if (fill_q == FILL_W'(k)) begin
        merged[k*PW +: PW] = pix_data;
      end
    end

    if (pix_valid) begin
      beat_c = pix_eof || (fill_q == FILL_W'(PIXELS_PER_BEAT - 1));
      if (beat_c) begin
        fill_d     = '0;
        asm_d      = '0;
        out_d.valid = 1'b1;
        out_d.data  = merged;
        out_d.slot  = beat_slot;
        out_d.last  = burst_last;
      end else begin
        fill_d = fill_q + FILL_W'(1);
        asm_d  = merged;
      end

      case (state_q)
        S_IDLE: begin
          slot_d = slot_id;
          if (!pix_eof) begin
            state_d = S_FRAME;
            fa_d    = 1'b1;
          end
        end
        S_FRAME: begin
          if (pix_eof) begin
            state_d = S_IDLE;
            fa_d    = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      fill_q  <= '0;
      asm_q   <= '0;
      slot_q  <= '0;
      fa_q    <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      asm_q   <= asm_d;
      slot_q  <= slot_d;
      fa_q    <= fa_d;
      out_q   <= out_d;
    end
  end

  assign pcie_packet_out = out_q;
  assign frame_active    = fa_q;

`ifdef PCIE_PIXEL_PACKER_STATS_EN
  logic [31:0] beats_q, beats_d;
  logic [15:0] frames_q, frames_d;

  // Saturating counters: stick at all-ones rather than wrap
  always_comb begin
    beats_d  = beats_q;
    frames_d = frames_q;
    if (beat_c && (beats_q != '1)) begin
      beats_d = beats_q + 32'(1);
    end
    if (beat_c && pix_eof && (frames_q != '1)) begin
      frames_d = frames_q + 16'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beats_q  <= '0;
      frames_q <= '0;
    end else begin
      beats_q  <= beats_d;
      frames_q <= frames_d;
    end
  end

  assign beats_sent  = beats_q;
  assign frames_sent = frames_q;
`endif

endmodule

// File: tb/tb_pcie_pixel_packer.sv
// Self-checking bench for pcie_pixel_packer in three geometries.
// Statistics checks are compiled in when PCIE_PIXEL_PACKER_STATS_EN is defined.
module tb_pcie_pixel_packer;
  import pcie_pixel_packer_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic [15:0] s0, s1, s2;
  logic        v0, v1, v2;
  logic        e0, e1, e2;
  logic [23:0] d0, d1;
  logic [7:0]  d2;
  PCIEPacket   o0, o1, o2;
  logic        fa0, fa1, fa2;
`ifdef PCIE_PIXEL_PACKER_STATS_EN
  logic [31:0] bs0, bs1, bs2;
  logic [15:0] fs0, fs1, fs2;
`endif

  pcie_pixel_packer u0 (
    .clk(clk), .rst(rst), .slot_id(s0), .pix_valid(v0), .pix_data(d0), .pix_eof(e0),
    .pcie_packet_out(o0), .frame_active(fa0)
`ifdef PCIE_PIXEL_PACKER_STATS_EN
    , .beats_sent(bs0), .frames_sent(fs0)
`endif
  );

  pcie_pixel_packer #(.CHANNELS(3), .PIXELS_PER_BEAT(1), .BURST_BEATS(4)) u1 (
    .clk(clk), .rst(rst), .slot_id(s1), .pix_valid(v1), .pix_data(d1), .pix_eof(e1),
    .pcie_packet_out(o1), .frame_active(fa1)
`ifdef PCIE_PIXEL_PACKER_STATS_EN
    , .beats_sent(bs1), .frames_sent(fs1)
`endif
  );

  pcie_pixel_packer #(.CHANNELS(1), .PIXELS_PER_BEAT(16)) u2 (
    .clk(clk), .rst(rst), .slot_id(s2), .pix_valid(v2), .pix_data(d2), .pix_eof(e2),
    .pcie_packet_out(o2), .frame_active(fa2)
`ifdef PCIE_PIXEL_PACKER_STATS_EN
    , .beats_sent(bs2), .frames_sent(fs2)
`endif
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic         v;
    logic         eof;
    logic [23:0]  pix;
    logic         ev;
    logic         el;
    logic [127:0] ed;
    logic         efa;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void push(input logic v, input logic eof, input logic [23:0] pix,
                               input logic ev, input logic el, input logic [127:0] ed,
                               input logic efa);
    vec_t r;
    r.v = v; r.eof = eof; r.pix = pix; r.ev = ev; r.el = el; r.ed = ed; r.efa = efa;
    tv.push_back(r);
  endfunction

  initial begin
    logic [127:0] acc;
    logic [23:0]  p;
    int           k;

    // Frame of 10 RGB pixels, then a 7-pixel frame starting the very next cycle
    acc = '0; k = 0;
    for (int i = 1; i <= 10; i++) begin
      p = {8'(i), 8'(i + 1), 8'(i + 2)};
      acc[k*24 +: 24] = p; k++;
      if (k == 5 || i == 10) begin
        push(1'b1, i == 10, p, 1'b1, i == 10, acc, i != 10);
        acc = '0; k = 0;
      end else begin
        push(1'b1, 1'b0, p, 1'b0, 1'b0, '0, 1'b1);
      end
    end
    for (int j = 1; j <= 7; j++) begin
      p = 24'(24'h111111 * j);
      acc[k*24 +: 24] = p; k++;
      if (k == 5 || j == 7) begin
        push(1'b1, j == 7, p, 1'b1, j == 7, acc, j != 7);
        acc = '0; k = 0;
      end else begin
        push(1'b1, 1'b0, p, 1'b0, 1'b0, '0, 1'b1);
      end
    end
    push(1'b0, 1'b1, 24'hFFFFFF, 1'b0, 1'b0, '0, 1'b0);
    push(1'b0, 1'b0, 24'h000000, 1'b0, 1'b0, '0, 1'b0);

    rst = 1'b0;
    s0 = 16'h0003; s1 = 16'h0001; s2 = 16'h00A5;
    v0 = 0; v1 = 0; v2 = 0; e0 = 0; e1 = 0; e2 = 0; d0 = '0; d1 = '0; d2 = '0;
    tick(); tick();
    chk("reset valid", 128'(o0.valid), 128'(0));
    chk("reset data", o0.data, 128'(0));
    chk("reset slot_last", 128'({o0.slot, o0.pad, o0.last}), 128'(0));
    chk("reset frame_active", 128'(fa0), 128'(0));
    rst = 1'b1;
    tick();

    // Table-driven frames on the default geometry
    for (int r = 0; r < tv.size(); r++) begin
      v0 = tv[r].v; e0 = tv[r].eof; d0 = tv[r].pix;
      tick();
      chk($sformatf("tbl r%0d valid", r), 128'(o0.valid), 128'(tv[r].ev));
      chk($sformatf("tbl r%0d frame_active", r), 128'(fa0), 128'(tv[r].efa));
      if (tv[r].ev) begin
        chk($sformatf("tbl r%0d last", r), 128'(o0.last), 128'(tv[r].el));
        chk($sformatf("tbl r%0d data", r), o0.data, tv[r].ed);
        chk($sformatf("tbl r%0d slot", r), 128'(o0.slot), 128'(16'h0003));
        chk($sformatf("tbl r%0d pad", r), 128'(o0.pad), 128'(0));
      end
    end
    v0 = 0; e0 = 0;

    // One pixel per beat, 4-beat bursts: last on beats 4, 8 and 9
    for (int i = 1; i <= 9; i++) begin
      v1 = 1'b1; e1 = (i == 9); d1 = 24'(i * 3 + 24'h100);
      tick();
      chk($sformatf("ppb1 b%0d valid", i), 128'(o1.valid), 128'(1));
      chk($sformatf("ppb1 b%0d last", i), 128'(o1.last), 128'(i == 4 || i == 8 || i == 9));
      chk($sformatf("ppb1 b%0d data", i), o1.data, 128'(24'(i * 3 + 24'h100)));
      chk($sformatf("ppb1 b%0d frame_active", i), 128'(fa1), 128'(i != 9));
    end
    v1 = 0; e1 = 0;
    tick();
    chk("ppb1 idle valid", 128'(o1.valid), 128'(0));

    // Gray, 16 per beat; slot_id changes mid-frame but the latched value is used
    acc = '0;
    for (int i = 1; i <= 32; i++) begin
      if (i == 8) s2 = 16'h00FF;
      v2 = 1'b1; e2 = (i == 32); d2 = 8'(i);
      acc[((i - 1) % 16)*8 +: 8] = 8'(i);
      tick();
      if (i % 16 == 0) begin
        chk($sformatf("gray b%0d valid", i), 128'(o2.valid), 128'(1));
        chk($sformatf("gray b%0d slot", i), 128'(o2.slot), 128'(16'h00A5));
        chk($sformatf("gray b%0d last", i), 128'(o2.last), 128'(i == 32));
        chk($sformatf("gray b%0d data", i), o2.data, acc);
        acc = '0;
      end else begin
        chk($sformatf("gray p%0d valid", i), 128'(o2.valid), 128'(0));
      end
    end
    v2 = 0; e2 = 0;
    tick();
    chk("gray frame_active end", 128'(fa2), 128'(0));

    // Reset mid-frame drops buffered pixels
    for (int i = 1; i <= 3; i++) begin
      v0 = 1'b1; e0 = 1'b0; d0 = 24'(24'h500000 + i);
      tick();
      chk($sformatf("rstmid p%0d valid", i), 128'(o0.valid), 128'(0));
    end
    v0 = 0;
    rst = 1'b0;
    #2;
    chk("rstmid async frame_active", 128'(fa0), 128'(0));
    chk("rstmid async valid", 128'(o0.valid), 128'(0));
    tick();
    rst = 1'b1;
    tick();
    acc = '0;
    for (int i = 1; i <= 5; i++) begin
      v0 = 1'b1; e0 = (i == 5); d0 = 24'(24'hA00000 + i);
      acc[(i - 1)*24 +: 24] = 24'(24'hA00000 + i);
      tick();
      chk($sformatf("rstnew p%0d valid", i), 128'(o0.valid), 128'(i == 5));
    end
    chk("rstnew last", 128'(o0.last), 128'(1));
    chk("rstnew data", o0.data, acc);
    v0 = 0; e0 = 0;
    tick();

    // Single-pixel frame: one beat, stays idle
    v0 = 1'b1; e0 = 1'b1; d0 = 24'h123456; s0 = 16'h0042;
    tick();
    chk("single valid", 128'(o0.valid), 128'(1));
    chk("single last", 128'(o0.last), 128'(1));
    chk("single data", o0.data, 128'(24'h123456));
    chk("single slot", 128'(o0.slot), 128'(16'h0042));
    chk("single frame_active", 128'(fa0), 128'(0));
    v0 = 0; e0 = 0;
    tick();
    chk("single after valid", 128'(o0.valid), 128'(0));

`ifdef PCIE_PIXEL_PACKER_STATS_EN
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("stats reset beats", 128'(bs0), 128'(0));
    chk("stats reset frames", 128'(fs0), 128'(0));
    chk("stats reset others", 128'({bs1, fs1, bs2, fs2}), 128'(0));
    tick();
    for (int f = 0; f < 3; f++) begin
      for (int i = 1; i <= 10; i++) begin
        v0 = 1'b1; e0 = (i == 10); d0 = 24'(i);
        tick();
      end
    end
    v0 = 0; e0 = 0;
    tick();
    chk("stats beats 3 frames", 128'(bs0), 128'(6));
    chk("stats frames 3 frames", 128'(fs0), 128'(3));
    v0 = 1'b1; e0 = 1'b1; d0 = 24'h0000AA;
    tick();
    v0 = 0; e0 = 0;
    tick();
    chk("stats beats single", 128'(bs0), 128'(7));
    chk("stats frames single", 128'(fs0), 128'(4));
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
